// File: rtl/xsim_msg_deframer.sv
// xsim_msg_deframer
//   Splits the simulator's 32-bit beat stream into framed output words.
//   Each message begins with a header beat {method[15:0], num_words[15:0]}
//   (num_words counts the header; 0 means 1). The payload words follow the
//   header. A header-only message produces a single nodata word.
//
// Ports
//   CLK, RST_N         clock; asynchronous active-low reset
//   src_rdy, beat      incoming beat. There is no backpressure, so a beat
//                      that finds the FIFO full is dropped.
//   out_valid/ready    output handshake
//   out_data           payload word (0 for nodata words)
//   out_method         method id of the current message
//   out_portal         constant PORTAL
//   out_first/last     message framing flags
//   out_nodata         the word is a header-only marker
//   overflow           sticky flag: a beat was dropped
//   msg_count          number of completed messages emitted
module xsim_msg_deframer #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] PORTAL     = 32'd0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        src_rdy,
    input  logic [31:0] beat,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [15:0] out_method,
    output logic [31:0] out_portal,
    output logic        out_first,
    output logic        out_last,
    output logic        out_nodata,
    output logic        overflow,
    output logic [31:0] msg_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {ST_HDR, ST_BODY} state_t;

    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    state_t        r_state;
    logic [15:0]   r_method;
    logic [15:0]   r_remaining;
    logic          r_first_pend;

    logic          r_out_valid;
    logic [31:0]   r_out_data;
    logic [15:0]   r_out_method;
    logic          r_out_first;
    logic          r_out_last;
    logic          r_out_nodata;
    logic [31:0]   r_msg_count;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_out_free;
    logic [31:0]   w_head;
    logic          w_hdr_multi;

    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_head      = r_mem[r_rd_ptr];
    // num_words of 0 and 1 both describe a header-only message
    assign w_hdr_multi = (w_head[15:0] > 16'd1);
    assign w_out_free  = !r_out_valid || out_ready;

    // A multi-word header pops without touching the output register, so it
    // does not wait for the output register to become free.
    always_comb begin
        w_pop = 1'b0;
        if (!w_empty) begin
            if (r_state == ST_BODY) w_pop = w_out_free;
            else                    w_pop = w_hdr_multi || w_out_free;
        end
    end

    // When the FIFO is full, a pop on the same edge frees the slot.
    assign w_push = src_rdy && (!w_full || w_pop);

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= beat;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            if (src_rdy && !w_push)    r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= ST_HDR;
            r_method     <= '0;
            r_remaining  <= '0;
            r_first_pend <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_method <= '0;
            r_out_first  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_nodata <= 1'b0;
            r_msg_count  <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
                if (r_out_last) r_msg_count <= r_msg_count + 32'd1;
            end
            if (w_pop) begin
                case (r_state)
                    ST_HDR: begin
                        if (w_hdr_multi) begin
                            r_method     <= w_head[31:16];
                            r_remaining  <= w_head[15:0] - 16'd1;
                            r_first_pend <= 1'b1;
                            r_state      <= ST_BODY;
                        end else begin
                            r_out_valid  <= 1'b1;
                            r_out_data   <= '0;
                            r_out_method <= w_head[31:16];
                            r_out_first  <= 1'b1;
                            r_out_last   <= 1'b1;
                            r_out_nodata <= 1'b1;
                        end
                    end
                    ST_BODY: begin
                        r_out_valid  <= 1'b1;
                        r_out_data   <= w_head;
                        r_out_method <= r_method;
                        r_out_first  <= r_first_pend;
                        r_out_last   <= (r_remaining == 16'd1);
                        r_out_nodata <= 1'b0;
                        r_first_pend <= 1'b0;
                        r_remaining  <= r_remaining - 16'd1;
                        if (r_remaining == 16'd1) r_state <= ST_HDR;
                    end
                    default: r_state <= ST_HDR;
                endcase
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_method = r_out_method;
    assign out_portal = PORTAL;
    assign out_first  = r_out_first;
    assign out_last   = r_out_last;
    assign out_nodata = r_out_nodata;
    assign overflow   = r_overflow;
    assign msg_count  = r_msg_count;

endmodule

// File: tb/tb_xsim_msg_deframer.sv
// tb_xsim_msg_deframer
//   Self-checking bench: per-cycle vector table for the basic framing cases,
//   hand-written sequences for stall/overflow/reset/wrap corners, and a
//   randomized message stream checked against an expected-word scoreboard
//   built directly from the message descriptions.
module tb_xsim_msg_deframer;

    localparam int unsigned DEPTH     = 8;
    localparam logic [31:0] TB_PORTAL = 32'hCAFE_0042;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        src_rdy = 1'b0;
    logic [31:0] beat = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [15:0] out_method;
    logic [31:0] out_portal;
    logic        out_first;
    logic        out_last;
    logic        out_nodata;
    logic        overflow;
    logic [31:0] msg_count;

    xsim_msg_deframer #(.FIFO_DEPTH(DEPTH), .PORTAL(TB_PORTAL)) dut (
        .CLK(CLK), .RST_N(RST_N), .src_rdy(src_rdy), .beat(beat),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_method(out_method), .out_portal(out_portal), .out_first(out_first),
        .out_last(out_last), .out_nodata(out_nodata), .overflow(overflow),
        .msg_count(msg_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        src;
        logic [31:0] bt;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic [15:0] em;
        logic        ef;
        logic        el;
        logic        en;
        logic [31:0] ec;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [15:0] method;
        logic        first;
        logic        last;
        logic        nodata;
        int          beats;
    } exp_t;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] tx_q[$];
    exp_t        exp_q[$];
    int          sent     = 0;
    int          consumed = 0;
    bit          g_limit  = 1'b0;
    vec_t        tv[9];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expands one message into its header/payload beats and expected words.
    task automatic add_msg(input logic [15:0] method, input logic [15:0] nw,
                           input logic [31:0] base, input bit rnd);
        int   nwe;
        exp_t e;
        nwe = (nw == 16'd0) ? 1 : int'(nw);
        tx_q.push_back({method, nw});
        if (nwe == 1) begin
            e = '{data: 32'd0, method: method, first: 1'b1, last: 1'b1, nodata: 1'b1, beats: 1};
            exp_q.push_back(e);
        end else begin
            for (int k = 1; k < nwe; k++) begin
                e.data   = rnd ? $urandom() : base + 32'(k);
                e.method = method;
                e.first  = (k == 1);
                e.last   = (k == nwe - 1);
                e.nodata = 1'b0;
                e.beats  = (k == 1) ? 2 : 1;
                tx_q.push_back(e.data);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_cycle(input bit src_en, input bit rdy);
        bit          do_src;
        bit          hold;
        logic [50:0] snap;
        exp_t        e;
        do_src    = src_en && (tx_q.size() > 0) &&
                    (!g_limit || (sent - consumed) < int'(DEPTH));
        src_rdy   = do_src;
        beat      = do_src ? tx_q[0] : $urandom();
        out_ready = rdy;
        if (out_valid && rdy) begin
            check("xfer_pending", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("xfer", {out_data, out_method, out_first, out_last, out_nodata},
                      {e.data, e.method, e.first, e.last, e.nodata});
                consumed += e.beats;
            end
        end
        hold = out_valid && !rdy;
        snap = {out_data, out_method, out_first, out_last, out_nodata};
        @(posedge CLK);
        if (do_src) begin
            tx_q.delete(0);
            sent++;
        end
        #1;
        if (hold) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_hold", {out_data, out_method, out_first, out_last, out_nodata}, snap);
        end
    endtask

    task automatic drain(input int max_cycles);
        for (int c = 0; c < max_cycles && (exp_q.size() > 0 || tx_q.size() > 0); c++)
            run_cycle(1'b1, 1'b1);
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        src_rdy = 1'b0;
        out_ready = 1'b0;
        tx_q.delete();
        exp_q.delete();
        sent = 0;
        consumed = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //        src bt            rdy  ev  ed            em       ef    el    en    ec
        tv[0] = '{1'b1, 32'h0005_0003, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0, 32'd0};
        tv[1] = '{1'b1, 32'h0000_000A, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0, 32'd0};
        tv[2] = '{1'b1, 32'h0000_000B, 1'b1, 1'b1, 32'hA, 16'h5, 1'b1, 1'b0, 1'b0, 32'd0};
        tv[3] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'hB, 16'h5, 1'b0, 1'b1, 1'b0, 32'd0};
        tv[4] = '{1'b1, 32'h0007_0001, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0, 32'd1};
        tv[5] = '{1'b1, 32'h0009_0002, 1'b1, 1'b1, 32'h0, 16'h7, 1'b1, 1'b1, 1'b1, 32'd1};
        tv[6] = '{1'b1, 32'h0000_0077, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0, 32'd2};
        tv[7] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h77, 16'h9, 1'b1, 1'b1, 1'b0, 32'd2};
        tv[8] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0, 32'd3};

        // Reset state, with beats presented during reset that must be ignored
        #3;
        check("rst_outputs", {out_valid, out_first, out_last, out_nodata, overflow,
                              out_data, out_method, msg_count}, '0);
        check("portal", out_portal, TB_PORTAL);
        src_rdy = 1'b1;
        beat    = 32'h0007_0001;
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        src_rdy = 1'b0;
        RST_N   = 1'b1;
        @(posedge CLK);
        #1;
        repeat (3) run_cycle(1'b0, 1'b1);
        check("rst_beats_ignored_ovf", overflow, 1'b0);
        check("rst_beats_ignored_vld", out_valid, 1'b0);

        // Vector table: two-word message, header-only message, one-word message
        for (int unsigned i = 0; i < 9; i++) begin
            src_rdy   = tv[i].src;
            beat      = tv[i].bt;
            out_ready = tv[i].rdy;
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d_valid", i), out_valid, tv[i].ev);
            check($sformatf("vec%0d_count", i), msg_count, tv[i].ec);
            if (tv[i].ev)
                check($sformatf("vec%0d_word", i),
                      {out_data, out_method, out_first, out_last, out_nodata},
                      {tv[i].ed, tv[i].em, tv[i].ef, tv[i].el, tv[i].en});
        end

        // Stalled output with overflow: 12-word message, out_ready held low
        do_reset();
        g_limit = 1'b0;
        add_msg(16'h0001, 16'd12, 32'h100, 1'b0);
        repeat (12) run_cycle(1'b1, 1'b0);
        check("ovf_set", overflow, 1'b1);
        check("ovf_held_word", {out_valid, out_data, out_first}, {1'b1, 32'h101, 1'b1});
        check("ovf_fifo_full", dut.r_count, DEPTH);
        repeat (12) run_cycle(1'b0, 1'b1);
        check("ovf_dropped_words", exp_q.size(), 2);
        check("ovf_sticky", overflow, 1'b1);

        // Async reset in the middle of a message, then a fresh message
        do_reset();
        add_msg(16'h0003, 16'd5, 32'h200, 1'b0);
        repeat (3) run_cycle(1'b1, 1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_rst_outputs", {out_valid, out_first, out_last, out_nodata, overflow,
                                    out_data, out_method, msg_count}, '0);
        src_rdy = 1'b0;
        tx_q.delete();
        exp_q.delete();
        sent = 0;
        consumed = 0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        add_msg(16'h0002, 16'd2, 32'h54, 1'b0);
        drain(20);
        check("async_rst_count", msg_count, 32'd1);

        // Full FIFO with simultaneous pop and push
        do_reset();
        add_msg(16'h0003, 16'd16, 32'h300, 1'b0);
        repeat (10) run_cycle(1'b1, 1'b0);
        check("full_count", dut.r_count, DEPTH);
        check("full_no_ovf", overflow, 1'b0);
        run_cycle(1'b1, 1'b1);
        check("full_pushpop_count", dut.r_count, DEPTH);
        check("full_pushpop_no_ovf", overflow, 1'b0);
        drain(100);
        check("full_msg_count", msg_count, 32'd1);
        check("full_final_no_ovf", overflow, 1'b0);

        // msg_count wrap
        force dut.r_msg_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_msg_count;
        check("wrap_preload", msg_count, 32'hFFFF_FFFF);
        add_msg(16'h0007, 16'd1, 32'h0, 1'b0);
        drain(20);
        check("wrap_count", msg_count, 32'd0);

        // Randomized message stream with random gaps and backpressure
        do_reset();
        g_limit = 1'b1;
        for (int unsigned m = 0; m < 60; m++)
            add_msg(16'($urandom()), 16'($urandom_range(0, 5)), 32'h0, 1'b1);
        for (int c = 0; c < 4000 && (exp_q.size() > 0 || tx_q.size() > 0); c++)
            run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        check("rand_all_words", exp_q.size(), 0);
        check("rand_msg_count", msg_count, 32'd60);
        check("rand_no_ovf", overflow, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/xsim_msg_deframer.md
XSIM_MSG_DEFRAMER -- requirements
Module: xsim_msg_deframer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, input beat FIFO entries; power of two, >=2.
REQ-002 Parameter PORTAL, default 0, portal number echoed on out_portal.
REQ-003 CLK  input  1  sole clock; all state changes on posedge CLK.
REQ-004 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 src_rdy  input  1  beat valid this cycle, driven by the simulator message sink; no backpressure path exists.
REQ-006 beat  input  32  message beat, meaningful only when src_rdy=1.
REQ-007 out_valid  output  1  out_* holds a valid word.
REQ-008 out_ready  input  1  downstream accepts; transfer = out_valid & out_ready.
REQ-009 out_data  output  32  payload word; 0 for header-only messages.
REQ-010 out_method  output  16  method id of the current message.
REQ-011 out_portal  output  32  constant PORTAL.
REQ-012 out_first  output  1  first word of a message.
REQ-013 out_last  output  1  last word of a message.
REQ-014 out_nodata  output  1  header-only message marker; out_data is not payload.
REQ-015 overflow  output  1  sticky: a beat was dropped.
REQ-016 msg_count  output  32  completed messages emitted; wraps 0xFFFFFFFF->0.

Function
REQ-017 Header beat format: [31:16] method id, [15:0] num_words including the header; num_words=0 SHALL be treated as 1.
REQ-018 Each src_rdy=1 beat SHALL be written into the FIFO at that posedge when the FIFO is not full, or when it is full and a pop occurs on the same edge.
REQ-019 A beat arriving while full with no same-edge pop SHALL be dropped, set overflow=1, and leave FIFO contents unchanged.
REQ-020 Parser FSM states: HDR, BODY.
REQ-021 In HDR, a FIFO entry with num_words>=2 SHALL be popped, latch method id, load remaining=num_words-1, and go to BODY; no output is produced.
REQ-022 In HDR, an entry with num_words<=1 SHALL pop only when the output register is free, and load out_first=out_last=out_nodata=1 with out_data=0; the FSM stays in HDR.
REQ-023 In BODY, a word SHALL pop only when the FIFO is non-empty and the output register is free (out_valid=0, or out_ready=1 on that edge).
REQ-024 A popped BODY word loads out_data; out_first=1 for the first payload word, out_last=1 when remaining=1, and remaining decrements.
REQ-025 The FSM SHALL return to HDR on the edge that loads the last word.
REQ-026 The output register SHALL hold all out_* stable while out_valid=1 and out_ready=0.
REQ-027 msg_count SHALL increment on each transfer with out_last=1.
REQ-028 Latency: a beat sampled at edge N with an empty pipeline and out_ready=1 SHALL be visible on out_* after edge N+1.
REQ-029 Sustained throughput SHALL be one payload word per cycle, plus one header cycle per message.
REQ-030 The FIFO SHALL use wrap-around pointers with a count, and full/empty SHALL be exact at FIFO_DEPTH entries.

Reset
REQ-031 RST_N=0 SHALL immediately force: out_valid=0, out_first=0, out_last=0, out_nodata=0, out_data=0, out_method=0, overflow=0, msg_count=0, FIFO empty, FSM=HDR, remaining=0.
REQ-032 Reset mid-message SHALL discard any partial message; the first beat accepted after release SHALL be parsed as a header.
REQ-033 Beats presented while RST_N=0 SHALL be ignored and SHALL NOT set overflow.

Verification
REQ-034 Header 0x0005_0003, then 0xA, 0xB at one beat per cycle, out_ready=1 -> two transfers: (0xA, method 5, first=1, last=0), then (0xB, first=0, last=1); msg_count=1.
REQ-035 Header 0x0007_0001 -> one transfer: nodata=1, first=last=1, data=0, method 7; the next beat is parsed as a header.
REQ-036 out_ready=0, FIFO_DEPTH=8, header 0x0001_000C plus 11 payload beats -> one word held in the output register, 8 in the FIFO, remaining dropped; overflow=1; out_* stable while stalled.
REQ-037 FIFO full, out_ready=1 and src_rdy=1 on the same edge -> beat accepted, no overflow, count unchanged.
REQ-038 RST_N pulsed low asynchronously after the 2nd of 4 payload beats -> all outputs zero immediately; a fresh message 0x0002_0002, 0x55 yields data=0x55, first=last=1.
REQ-039 msg_count preloaded to 0xFFFFFFFF via force, then one message completes -> msg_count=0.
